// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: opcodes, pc_src codes, decode FSM states, read-stage bundle
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ALU_RR = 4'h1,
    OP_ALU_RI = 4'h2,
    OP_BR     = 4'h3,
    OP_JABS   = 4'h4,
    OP_JR     = 4'h5
  } opcode_e;

  localparam logic [1:0] PC_SRC_REG = 2'b00;
  localparam logic [1:0] PC_SRC_REL = 2'b01;
  localparam logic [1:0] PC_SRC_ABS = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_OP   = 2'd0;
  localparam state_t ST_EXT1 = 2'd1;
  localparam state_t ST_EXT2 = 2'd2;

  typedef struct packed {
    logic        read_a;
    logic        imm5_a;
    logic [4:0]  arg_a;
    logic        read_b;
    logic [3:0]  arg_b;
    logic [2:0]  cmp_b;
    logic        pc_set;
    logic        pc_add;
    logic        pc_inc;
    logic [1:0]  pc_src;
    logic [30:0] ext_imm;
    logic        illegal;
  } bundle_t;

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-to-decode handshake and decode-to-read-stage bundle signals
interface decode_if;

  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic        dec_valid;
  logic        read_a;
  logic        imm5_a;
  logic [4:0]  arg_a;
  logic        read_b;
  logic [3:0]  arg_b;
  logic [2:0]  cmp_b;
  logic        pc_set;
  logic        pc_add;
  logic        pc_inc;
  logic [1:0]  pc_src;
  logic [30:0] ext_imm;
  logic        illegal;

  modport slave (
    input  instr_valid, instr, stall, flush,
    output instr_ready, dec_valid, read_a, imm5_a, arg_a, read_b, arg_b,
           cmp_b, pc_set, pc_add, pc_inc, pc_src, ext_imm, illegal
  );

  modport master (
    output instr_valid, instr, stall, flush,
    input  instr_ready, dec_valid, read_a, imm5_a, arg_a, read_b, arg_b,
           cmp_b, pc_set, pc_add, pc_inc, pc_src, ext_imm, illegal
  );

endinterface

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - opcode word to control-field table; JABS decode under DECODE_JUMP_ABS_EN
module decode_fields
  import cpu_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [10:0] operand,
  output bundle_t     fields,
  output logic        needs_ext
);

  // Table lookup; ext_imm is left zero and filled in by the top from extension words
  always_comb begin
    fields    = '0;
    needs_ext = 1'b0;
    case (opcode)
      OP_NOP: begin
        fields.pc_inc = 1'b1;
      end
      OP_ALU_RR: begin
        fields.read_a = 1'b1;
        fields.arg_a  = {1'b0, operand[7:4]};
        fields.read_b = 1'b1;
        fields.arg_b  = operand[3:0];
        fields.pc_inc = 1'b1;
      end
      OP_ALU_RI: begin
        fields.imm5_a = 1'b1;
        fields.arg_a  = operand[8:4];
        fields.read_b = 1'b1;
        fields.arg_b  = operand[3:0];
        fields.pc_inc = 1'b1;
      end
      OP_BR: begin
        fields.read_a = 1'b1;
        fields.arg_a  = {1'b0, operand[7:4]};
        fields.read_b = 1'b1;
        fields.arg_b  = operand[3:0];
        fields.cmp_b  = operand[10:8];
        fields.pc_add = 1'b1;
        fields.pc_src = PC_SRC_REL;
        needs_ext     = 1'b1;
      end
`ifdef DECODE_JUMP_ABS_EN
      OP_JABS: begin
        fields.pc_set = 1'b1;
        fields.pc_src = PC_SRC_ABS;
        needs_ext     = 1'b1;
      end
`endif
      OP_JR: begin
        fields.read_a = 1'b1;
        fields.arg_a  = {1'b0, operand[7:4]};
        fields.pc_set = 1'b1;
        fields.pc_src = PC_SRC_REG;
      end
      default: begin
        fields.pc_inc  = 1'b1;
        fields.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - instruction decode stage: multi-word assembly FSM and registered bundle; JABS under DECODE_JUMP_ABS_EN
module decode
  import cpu_pkg::*;
(
  input  logic     cpu_clk,
  input  logic     cpu_rst,
  decode_if.slave  bus
);

  state_t      state_q;
  logic [14:0] op_q;        // opcode word minus bit 11: {opcode, operand[10:0]}
`ifdef DECODE_JUMP_ABS_EN
  logic [14:0] ext1_q;      // first JABS extension word, bit 15 is don't-care
`endif
  bundle_t     out_q;
  logic        dec_valid_q;

  logic        accept;
  logic [14:0] cur_op;
  bundle_t     fields;
  bundle_t     next_bundle;
  logic        needs_ext;

  assign bus.instr_ready = cpu_rst && !bus.flush && !(dec_valid_q && bus.stall);
  assign accept          = bus.instr_valid && bus.instr_ready;

  // In OP the live word is decoded; while extensions are awaited the latched opcode word is
  assign cur_op = (state_q == ST_OP) ? {bus.instr[15:12], bus.instr[10:0]} : op_q;

  decode_fields u_fields (
    .opcode    (cur_op[14:11]),
    .operand   (cur_op[10:0]),
    .fields    (fields),
    .needs_ext (needs_ext)
  );

  // Merge the extension immediate for the word that completes a multi-word instruction
  always_comb begin
    next_bundle = fields;
    case (state_q)
      ST_EXT1:  next_bundle.ext_imm = {{15{bus.instr[15]}}, bus.instr};
`ifdef DECODE_JUMP_ABS_EN
      ST_EXT2:  next_bundle.ext_imm = {ext1_q, bus.instr};
`endif
      default:  next_bundle.ext_imm = '0;
    endcase
  end

  // FSM, partial-instruction latches and bundle register; reset/flush win, then stall holds
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst || bus.flush) begin
      state_q     <= ST_OP;
      op_q        <= '0;
`ifdef DECODE_JUMP_ABS_EN
      ext1_q      <= '0;
`endif
      out_q       <= '0;
      dec_valid_q <= 1'b0;
    end else if (!(dec_valid_q && bus.stall)) begin
      out_q       <= '0;
      dec_valid_q <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_OP: begin
            if (needs_ext) begin
              op_q    <= cur_op;
              state_q <= ST_EXT1;
            end else begin
              out_q       <= next_bundle;
              dec_valid_q <= 1'b1;
            end
          end
          ST_EXT1: begin
`ifdef DECODE_JUMP_ABS_EN
            if (op_q[14:11] == OP_JABS) begin
              ext1_q  <= bus.instr[14:0];
              state_q <= ST_EXT2;
            end else
`endif
            begin
              out_q       <= next_bundle;
              dec_valid_q <= 1'b1;
              state_q     <= ST_OP;
            end
          end
`ifdef DECODE_JUMP_ABS_EN
          ST_EXT2: begin
            out_q       <= next_bundle;
            dec_valid_q <= 1'b1;
            state_q     <= ST_OP;
          end
`endif
          default: state_q <= ST_OP;
        endcase
      end
    end
  end

  assign bus.dec_valid = dec_valid_q;
  assign bus.read_a    = out_q.read_a;
  assign bus.imm5_a    = out_q.imm5_a;
  assign bus.arg_a     = out_q.arg_a;
  assign bus.read_b    = out_q.read_b;
  assign bus.arg_b     = out_q.arg_b;
  assign bus.cmp_b     = out_q.cmp_b;
  assign bus.pc_set    = out_q.pc_set;
  assign bus.pc_add    = out_q.pc_add;
  assign bus.pc_inc    = out_q.pc_inc;
  assign bus.pc_src    = out_q.pc_src;
  assign bus.ext_imm   = out_q.ext_imm;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - self-checking bench for decode; JABS expectations follow DECODE_JUMP_ABS_EN
module tb_decode;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  decode_if bus ();

  decode dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words of the instruction collected so far, and the expected output vector
  logic [15:0] words[$];
  logic [52:0] exp_vec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [52:0] dut_vec();
    return {bus.dec_valid, bus.read_a, bus.imm5_a, bus.arg_a, bus.read_b, bus.arg_b,
            bus.cmp_b, bus.pc_set, bus.pc_add, bus.pc_inc, bus.pc_src, bus.ext_imm, bus.illegal};
  endfunction

  function automatic int words_needed(input logic [3:0] op);
    if (op == 4'h3) return 2;
`ifdef DECODE_JUMP_ABS_EN
    if (op == 4'h4) return 3;
`endif
    return 1;
  endfunction

  function automatic logic [52:0] model_bundle(input logic [15:0] w0, input logic [15:0] w1,
                                               input logic [15:0] w2);
    logic       ra, ia, rb, ps, pa, pi, ill;
    logic [4:0] aa;
    logic [3:0] ab;
    logic [2:0] cb;
    logic [1:0] src;
    logic [30:0] ext;
    ra = 0; ia = 0; rb = 0; ps = 0; pa = 0; pi = 0; ill = 0;
    aa = 0; ab = 0; cb = 0; src = 0; ext = 0;
    case (w0[15:12])
      4'h0: pi = 1;
      4'h1: begin ra = 1; aa = 5'(w0[7:4]); rb = 1; ab = w0[3:0]; pi = 1; end
      4'h2: begin ia = 1; aa = w0[8:4]; rb = 1; ab = w0[3:0]; pi = 1; end
      4'h3: begin
        ra = 1; aa = 5'(w0[7:4]); rb = 1; ab = w0[3:0]; cb = w0[10:8]; pa = 1; src = 2'd1;
        ext = w1[15] ? (31'h7FFF0000 | 31'(w1)) : 31'(w1);
      end
`ifdef DECODE_JUMP_ABS_EN
      4'h4: begin ps = 1; src = 2'd2; ext = 31'(w1 & 16'h7FFF) * 31'd65536 + 31'(w2); end
`endif
      4'h5: begin ra = 1; aa = 5'(w0[7:4]); ps = 1; src = 2'd0; end
      default: begin pi = 1; ill = 1; end
    endcase
    return {1'b1, ra, ia, aa, rb, ab, cb, ps, pa, pi, src, ext, ill};
  endfunction

  // One clock: drive inputs, check ready, advance model, check registered outputs
  task automatic step(input logic v, input logic [15:0] w, input logic s, input logic f,
                      input logic r);
    logic [15:0] w0, w1, w2;
    bus.instr_valid = v;
    bus.instr       = w;
    bus.stall       = s;
    bus.flush       = f;
    rst             = r;
    #1;
    check("instr_ready", bus.instr_ready, r && !f && !(exp_vec[52] && s));
    if (!r || f) begin
      words.delete();
      exp_vec = '0;
    end else if (!(exp_vec[52] && s)) begin
      exp_vec = '0;
      if (v) begin
        words.push_back(w);
        w0 = words[0];
        if (words.size() == words_needed(w0[15:12])) begin
          w1 = (words.size() > 1) ? words[1] : 16'h0;
          w2 = (words.size() > 2) ? words[2] : 16'h0;
          exp_vec = model_bundle(w0, w1, w2);
          words.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check("bundle", dut_vec(), exp_vec);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_vec  = '0;
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);

    // Reset
    step(1, 16'h1034, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0);
    check("rst_valid", bus.dec_valid, 0);
    check("rst_ext_imm", bus.ext_imm, 0);

    // Back-to-back single-word instructions
    step(1, 16'h1034, 0, 0, 1);
    check("rr_valid", bus.dec_valid, 1);
    check("rr_arg_a", bus.arg_a, 3);
    check("rr_arg_b", bus.arg_b, 4);
    step(1, 16'hF000, 0, 0, 1);
    check("ill_flag", bus.illegal, 1);
    check("ill_pc_inc", bus.pc_inc, 1);

    // Branch with negative offset
    step(1, 16'h3534, 0, 0, 1);
    check("br_wait", bus.dec_valid, 0);
    step(1, 16'hFFFE, 0, 0, 1);
    check("br_cmp_b", bus.cmp_b, 5);
    check("br_pc_src", bus.pc_src, 1);
    check("br_ext_imm", bus.ext_imm, 31'h7FFFFFFE);

    // Absolute jump
    step(1, 16'h4000, 0, 0, 1);
`ifdef DECODE_JUMP_ABS_EN
    step(1, 16'h0012, 0, 0, 1);
    step(1, 16'h3456, 0, 0, 1);
    check("jabs_pc_set", bus.pc_set, 1);
    check("jabs_ext_imm", bus.ext_imm, 31'h00123456);
`else
    check("jabs_illegal", bus.illegal, 1);
`endif

    // Stall holds the bundle and blocks acceptance until it drops
    step(1, 16'h2154, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h5070, 1, 0, 1);
      check("stall_arg_a", bus.arg_a, 5'h15);
      check("stall_imm5_a", bus.imm5_a, 1);
    end
    step(1, 16'h5070, 0, 0, 1);
    check("after_stall_jr", bus.pc_set, 1);

    // Flush drops a partial branch
    step(1, 16'h3534, 0, 0, 1);
    step(0, 16'h0000, 0, 1, 1);
    step(1, 16'h0000, 0, 0, 1);
    check("flush_nop_inc", bus.pc_inc, 1);
    check("flush_nop_add", bus.pc_add, 0);

    // Reset mid-instruction
    step(1, 16'h3534, 0, 0, 1);
    step(1, 16'hFFFE, 0, 0, 0);
    check("midrst_ready", bus.instr_ready, 0);
    step(1, 16'h0000, 0, 0, 1);
    check("midrst_nop_inc", bus.pc_inc, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int          k;
      logic [3:0]  op;
      logic [15:0] w;
      k  = $urandom_range(0, 7);
      op = (k >= 6) ? 4'($urandom_range(6, 15)) : 4'(k);
      w  = {op, 12'($urandom)};
      if ($urandom_range(0, 3) == 0) w = 16'($urandom);
      step($urandom_range(0, 9) < 8, w, $urandom_range(0, 9) < 3,
           $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
